// File: rtl/alu_pkg.sv
// Shared op codes and default datapath width for the execute-stage ALU.
// Latency: none (declarations only).
// Backpressure: none.
package alu_pkg;

    localparam int WIDTH = 32;

    localparam logic [3:0] ALU_AND  = 4'd0;
    localparam logic [3:0] ALU_OR   = 4'd1;
    localparam logic [3:0] ALU_ADD  = 4'd2;
    localparam logic [3:0] ALU_XOR  = 4'd3;
    localparam logic [3:0] ALU_SLL  = 4'd4;
    localparam logic [3:0] ALU_SRL  = 4'd5;
    localparam logic [3:0] ALU_SUB  = 4'd6;
    localparam logic [3:0] ALU_SLT  = 4'd7;
    localparam logic [3:0] ALU_SRA  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd10;
    localparam logic [3:0] ALU_NOR  = 4'd12;

endpackage

// File: rtl/alu_addsub.sv
// Shared adder/subtractor feeding ADD, SUB and both set-less-than ops.
// Latency: combinational.
// Backpressure: none.
module alu_addsub #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    logic [WIDTH-1:0] w_b_eff;

    // Subtract is A + ~B + 1; carry_out=1 on subtract means no borrow (A >= B unsigned).
    always_comb begin
        w_b_eff              = sub ? ~b : b;
        {carry_out, sum}     = {1'b0, a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, sub};
        overflow             = (a[WIDTH-1] == w_b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    end

endmodule

// File: rtl/mips_alu.sv
// Registered 32-bit MIPS execute-stage ALU with Zero flag; ALU_EXT_OPS_EN adds XOR/shifts/SLTU.
// Latency: 1 cycle, result and Zero registered from the inputs sampled at the edge.
// Backpressure: none, one operation accepted every cycle.
module mips_alu
    import alu_pkg::*;
#(
    parameter int W = WIDTH
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] entradaA,
    input  logic [W-1:0] entradaB,
    input  logic [3:0]   entradaControl,
    output logic [W-1:0] ALUresult,
    output logic         Zero
);

    localparam int SHW = $clog2(W);

    logic [W-1:0] w_sum;
    logic         w_carry;
    logic         w_ovf;
    logic         w_sub;
    logic         w_slt;
    logic [W-1:0] w_result;
    logic [W-1:0] r_result;
    logic         r_zero;

    // Every compare op runs the adder in subtract mode.
    assign w_sub = (entradaControl == ALU_SUB) || (entradaControl == ALU_SLT)
                || (entradaControl == ALU_SLTU);

    alu_addsub #(.WIDTH(W)) u_addsub (
        .a         (entradaA),
        .b         (entradaB),
        .sub       (w_sub),
        .sum       (w_sum),
        .carry_out (w_carry),
        .overflow  (w_ovf)
    );

    // Signed less-than corrected for overflow of A - B.
    assign w_slt = w_sum[W-1] ^ w_ovf;

`ifdef ALU_EXT_OPS_EN
    logic [SHW-1:0] w_shamt;
    logic           w_sltu;

    assign w_shamt = entradaA[SHW-1:0];
    // Borrow out of A - B means A < B unsigned.
    assign w_sltu  = ~w_carry;
`else
    logic w_unused_carry;

    assign w_unused_carry = w_carry;
`endif

    // Operation select; unknown codes produce zero so nothing undefined reaches the register.
    always_comb begin
        w_result = '0;
        case (entradaControl)
            ALU_AND:  w_result = entradaA & entradaB;
            ALU_OR:   w_result = entradaA | entradaB;
            ALU_ADD:  w_result = w_sum;
            ALU_SUB:  w_result = w_sum;
            ALU_SLT:  w_result = {{(W-1){1'b0}}, w_slt};
            ALU_NOR:  w_result = ~(entradaA | entradaB);
`ifdef ALU_EXT_OPS_EN
            ALU_XOR:  w_result = entradaA ^ entradaB;
            ALU_SLL:  w_result = entradaB << w_shamt;
            ALU_SRL:  w_result = entradaB >> w_shamt;
            ALU_SRA:  w_result = $unsigned($signed(entradaB) >>> w_shamt);
            ALU_SLTU: w_result = {{(W-1){1'b0}}, w_sltu};
`endif
            default:  w_result = '0;
        endcase
    end

    // Output register; Zero is taken from the next result so it always tracks ALUresult.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_result <= '0;
            r_zero   <= 1'b1;
        end else begin
            r_result <= w_result;
            r_zero   <= (w_result == '0);
        end
    end

    assign ALUresult = r_result;
    assign Zero      = r_zero;

endmodule

// File: tb/tb_mips_alu.sv
// Self-checking bench for mips_alu: directed corner cases plus random ops against a behavioural model.
// Latency: expects results one edge after inputs are applied.
// Backpressure: none, drives one op per cycle.
module tb_mips_alu;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] entradaA;
    logic [31:0] entradaB;
    logic [3:0]  entradaControl;
    logic [31:0] ALUresult;
    logic        Zero;

    int checks = 0;
    int errors = 0;

    mips_alu dut (
        .clk            (clk),
        .reset          (reset),
        .entradaA       (entradaA),
        .entradaB       (entradaB),
        .entradaControl (entradaControl),
        .ALUresult      (ALUresult),
        .Zero           (Zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Behavioural reference: the arithmetic meaning of each op code.
    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [31:0] sb;
        int                 sh;
        sb = b;
        sh = int'(a % 32);
        case (op)
            4'd0:  return a & b;
            4'd1:  return a | b;
            4'd2:  return a + b;
            4'd6:  return a - b;
            4'd7:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd12: return ~(a | b);
`ifdef ALU_EXT_OPS_EN
            4'd3:  return a ^ b;
            4'd4:  return b << sh;
            4'd5:  return b >> sh;
            4'd8:  return sb >>> sh;
            4'd10: return (a < b) ? 32'd1 : 32'd0;
`endif
            default: return 32'd0;
        endcase
    endfunction

    // Apply one op at the falling edge, check result and Zero just after the next rising edge.
    task automatic run_exp(input string tag, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp);
        @(negedge clk);
        entradaControl = op;
        entradaA       = a;
        entradaB       = b;
        @(posedge clk);
        #1;
        chk({tag, "_res"}, ALUresult, exp);
        chk({tag, "_zero"}, {31'd0, Zero}, {31'd0, exp == 32'd0});
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            4:       return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [31:0] held;

        reset          = 1'b1;
        entradaA       = 32'd3;
        entradaB       = 32'd2;
        entradaControl = 4'd2;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_res", ALUresult, 32'd0);
        chk("reset_zero", {31'd0, Zero}, 32'd1);

        @(negedge clk);
        reset = 1'b0;

        // Sequence of base ops on A=3, B=2.
        run_exp("undef9",  4'd9,  32'd3, 32'd2, 32'd0);
        run_exp("and",     4'd0,  32'd3, 32'd2, 32'd2);
        run_exp("or",      4'd1,  32'd3, 32'd2, 32'd3);
        run_exp("add",     4'd2,  32'd3, 32'd2, 32'd5);
        run_exp("sub",     4'd6,  32'd3, 32'd2, 32'd1);
        run_exp("nor",     4'd12, 32'd3, 32'd2, 32'hFFFF_FFFC);
        run_exp("undef9b", 4'd9,  32'd3, 32'd2, 32'd0);
        run_exp("undef15", 4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);

        // Reset wins over a pending ADD, then the ADD completes after release.
        @(negedge clk);
        entradaControl = 4'd2;
        entradaA       = 32'd5;
        entradaB       = 32'd5;
        reset          = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_res", ALUresult, 32'd0);
        chk("midrst_zero", {31'd0, Zero}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("postrst_res", ALUresult, 32'd10);
        chk("postrst_zero", {31'd0, Zero}, 32'd0);

        // Wrap-around and compare corners.
        run_exp("sub_eq",   4'd6, 32'd7,          32'd7,          32'd0);
        run_exp("add_wrap", 4'd2, 32'hFFFF_FFFF,  32'd1,          32'd0);
        run_exp("sub_wrap", 4'd6, 32'd0,          32'd1,          32'hFFFF_FFFF);
        run_exp("slt_neg",  4'd7, 32'h8000_0000,  32'd1,          32'd1);
        run_exp("slt_pos",  4'd7, 32'd1,          32'h8000_0000,  32'd0);
        run_exp("slt_eq",   4'd7, 32'd5,          32'd5,          32'd0);
        run_exp("slt_ovf",  4'd7, 32'h7FFF_FFFF,  32'hFFFF_FFFF,  32'd0);

`ifdef ALU_EXT_OPS_EN
        run_exp("srav",   4'd8,  32'd4, 32'h8000_0000, 32'hF800_0000);
        run_exp("sltu",   4'd10, 32'd1, 32'hFFFF_FFFF, 32'd1);
        run_exp("xor",    4'd3,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0);
        run_exp("sllv",   4'd4,  32'd36, 32'h0000_0001, 32'h0000_0010);
        run_exp("srlv",   4'd5,  32'd4, 32'h8000_0000, 32'h0800_0000);
`else
        run_exp("code3",  4'd3,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0);
        run_exp("code8",  4'd8,  32'd4, 32'h8000_0000, 32'd0);
        run_exp("code10", 4'd10, 32'd1, 32'hFFFF_FFFF, 32'd0);
`endif

        // Inputs changing after the edge must not disturb the registered output.
        run_exp("hold_base", 4'd2, 32'd100, 32'd23, 32'd123);
        held = ALUresult;
        entradaA       = 32'd1;
        entradaB       = 32'd1;
        entradaControl = 4'd6;
        #2;
        chk("hold_mid", ALUresult, held);

        // Random back-to-back ops, each checked against the inputs of the previous edge.
        for (int i = 0; i < 400; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = pick_operand();
            b  = pick_operand();
            run_exp($sformatf("rnd%0d_op%0d", i, op), op, a, b, ref_alu(op, a, b));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
